axis_operand_issuer: RTL and testbench
======================================

Name: axis_operand_issuer

Overview:
- Upstream sequencer for the floating-point sum-of-squares/reciprocal chain.
- On each sample trigger it captures a pair of 32-bit operands and presents them on two independent AXI-stream master channels (A and B) with correct valid/ready holding.
- It then waits for the chain's final result beat, latches it for readout, and counts overruns and timeouts.
- Replaces the practice of driving tvalid directly from a one-cycle trigger.

Parameters:
- WIDTH, 32, operand and result data width in bits.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT_RESULT before abort; must be ≥ 2.
- CNT_WIDTH, 16, width of the saturating overrun and timeout counters.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- trigger_in  in  1  single-cycle sample request.
- a_in  in  WIDTH  operand A, sampled on an accepted trigger.
- b_in  in  WIDTH  operand B, sampled on an accepted trigger.
- m_axis_a_tdata  out  WIDTH  channel A data.
- m_axis_a_tvalid  out  1  channel A valid.
- m_axis_a_tready  in  1  channel A ready.
- m_axis_b_tdata  out  WIDTH  channel B data.
- m_axis_b_tvalid  out  1  channel B valid.
- m_axis_b_tready  in  1  channel B ready.
- s_axis_result_tdata  in  WIDTH  result data from the end of the chain.
- s_axis_result_tvalid  in  1  result valid.
- s_axis_result_tready  out  1  result ready.
- result_out  out  WIDTH  last accepted result, held until the next one.
- result_valid_out  out  1  one-cycle pulse when result_out updates.
- busy_out  out  1  high when state is not IDLE.
- timeout_out  out  1  one-cycle pulse on a WAIT_RESULT abort.
- overrun_count_out  out  CNT_WIDTH  triggers ignored while busy; saturating.
- timeout_count_out  out  CNT_WIDTH  number of aborts; saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: tvalids, tdata, result_out, pulses, counters.
  - s_axis_result_tready = 1.
  - Assertion mid-transfer drops both tvalids immediately, without waiting for a clock edge.
- States: IDLE, ISSUE, WAIT_RESULT.
- IDLE:
  - trigger_in=1 → register a_in/b_in into m_axis_a_tdata/m_axis_b_tdata, set both tvalids, go to ISSUE. tvalid is visible 1 cycle after the trigger.
  - s_axis_result_tready=1; any beats arriving in IDLE (stale post-timeout results) are discarded. result_out is unchanged and no pulse is generated.
- ISSUE:
  - Each channel independently: if tvalid & tready at an edge, clear that tvalid next cycle.
  - tdata stays stable while its tvalid is high; tvalid never drops without a handshake.
  - When both channels have completed (in the same cycle or different cycles), go to WAIT_RESULT.
  - s_axis_result_tready=0.
  - No timeout in ISSUE.
- WAIT_RESULT:
  - s_axis_result_tready=1; the timer counts from 0.
  - On s_axis_result_tvalid: result_out ← tdata and result_valid_out=1 on the next cycle; go to IDLE that same cycle.
  - If the timer reaches TIMEOUT_CYCLES−1 with no result: pulse timeout_out, increment timeout_count_out, go to IDLE.
  - A result arriving in the same cycle as timer expiry is accepted; it is not counted as a timeout.
- Overrun: trigger_in=1 while state≠IDLE increments overrun_count_out and is otherwise ignored. This includes the cycle in which a result is accepted, because state is still WAIT_RESULT.
  - A trigger in the first IDLE cycle after completion is accepted.
- Counters saturate at all-ones; no wrap.
- Best-case latency with ready always high:
  - trigger at cycle 0 → handshakes at cycle 1 → WAIT_RESULT from cycle 2.
  - Result at cycle N → result_valid_out at N+1, IDLE at N+1.
- busy_out = (state≠IDLE), registered with the state.

Test Plan:
- Both treadys held 1; trigger with a_in=0x40400000, b_in=0x40800000; result 0x3D23D70A returned at cycle 10. Required:
  - Both tvalids high only at cycle 1, tdata matching the operands.
  - result_valid_out pulses at cycle 11 with result_out=0x3D23D70A.
  - busy_out low from cycle 11.
- Backpressure: A tready asserted at cycle 3, B at cycle 6. Required:
  - A tvalid high cycles 1–3; B tvalid high cycles 1–6; tdata stable throughout.
  - WAIT_RESULT entered at cycle 7.
- Triggers at cycles 0, 2 and 5 with the result at cycle 8, then another trigger at the result cycle and one at cycle 9. Required:
  - overrun_count_out=3.
  - The cycle-9 trigger is accepted (tvalid at 10).
- TIMEOUT_CYCLES=16, no result returned. Required:
  - timeout_out pulses once; timeout_count_out=1; IDLE follows.
  - A late result beat is consumed with no result_valid_out and result_out unchanged.
- Result arriving on the exact expiry cycle. Required: result accepted, timeout_count_out unchanged.
- rst_in asserted mid-ISSUE (A done, B pending). Required:
  - Tvalids drop without a clock edge; all outputs return to reset values.
  - A subsequent trigger issues normally.

Source files
------------

// File: rtl/axis_operand_issuer.sv
// axis_operand_issuer
//   Upstream sequencer for the floating-point sum-of-squares/reciprocal chain.
//   A sample trigger captures operand A and B into two independent AXI-stream
//   master channels. Each tvalid is held until its own handshake. The block
//   then waits for one result beat, latches it for readout, and aborts after
//   TIMEOUT_CYCLES. Triggers seen while busy are counted as overruns, and
//   aborts are counted as timeouts. Both counters saturate.
//
// Ports
//   clk_in, rst_in            clock; async active-high reset (release is
//                             expected to be synchronous to clk_in)
//   trigger_in, a_in, b_in    sample request and the operands it captures
//   m_axis_a_*, m_axis_b_*    operand output streams (tdata/tvalid/tready)
//   s_axis_result_*           result input stream from the end of the chain
//   result_out                last accepted result
//   result_valid_out          one-cycle pulse when result_out updates
//   busy_out                  high whenever state is not IDLE
//   timeout_out               one-cycle pulse on a result-wait abort
//   overrun_count_out         triggers ignored while busy (saturating)
//   timeout_count_out         number of aborts (saturating)
module axis_operand_issuer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trigger_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     m_axis_a_tdata,
  output logic                 m_axis_a_tvalid,
  input  logic                 m_axis_a_tready,
  output logic [WIDTH-1:0]     m_axis_b_tdata,
  output logic                 m_axis_b_tvalid,
  input  logic                 m_axis_b_tready,
  input  logic [WIDTH-1:0]     s_axis_result_tdata,
  input  logic                 s_axis_result_tvalid,
  output logic                 s_axis_result_tready,
  output logic [WIDTH-1:0]     result_out,
  output logic                 result_valid_out,
  output logic                 busy_out,
  output logic                 timeout_out,
  output logic [CNT_WIDTH-1:0] overrun_count_out,
  output logic [CNT_WIDTH-1:0] timeout_count_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 a_vld_q, a_vld_d;
  logic                 b_vld_q, b_vld_d;
  logic [WIDTH-1:0]     a_data_q, a_data_d;
  logic [WIDTH-1:0]     b_data_q, b_data_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 result_vld_q, result_vld_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] overrun_cnt_q, overrun_cnt_d;
  logic [CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    a_vld_d       = a_vld_q;
    b_vld_d       = b_vld_q;
    a_data_d      = a_data_q;
    b_data_d      = b_data_q;
    timer_d       = timer_q;
    result_d      = result_q;
    result_vld_d  = 1'b0;
    timeout_d     = 1'b0;
    overrun_cnt_d = overrun_cnt_q;
    timeout_cnt_d = timeout_cnt_q;

    // The result-accept cycle still counts as busy, so a trigger there is an overrun.
    if (trigger_in && (state_q != ST_IDLE)) begin
      overrun_cnt_d = sat_inc(overrun_cnt_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger_in) begin
          a_data_d = a_in;
          b_data_d = b_in;
          a_vld_d  = 1'b1;
          b_vld_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (a_vld_q && m_axis_a_tready) a_vld_d = 1'b0;
        if (b_vld_q && m_axis_b_tready) b_vld_d = 1'b0;
        // Both channels are done once neither valid survives this edge.
        if (!a_vld_d && !b_vld_d) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result on the expiry cycle wins over the timeout.
        if (s_axis_result_tvalid) begin
          result_d     = s_axis_result_tdata;
          result_vld_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d     = 1'b1;
          timeout_cnt_d = sat_inc(timeout_cnt_q);
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      a_vld_q       <= 1'b0;
      b_vld_q       <= 1'b0;
      a_data_q      <= '0;
      b_data_q      <= '0;
      timer_q       <= '0;
      result_q      <= '0;
      result_vld_q  <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      overrun_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      a_vld_q       <= a_vld_d;
      b_vld_q       <= b_vld_d;
      a_data_q      <= a_data_d;
      b_data_q      <= b_data_d;
      timer_q       <= timer_d;
      result_q      <= result_d;
      result_vld_q  <= result_vld_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      overrun_cnt_q <= overrun_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Results are refused only while operands are still being issued; in IDLE
  // any late beat is drained and dropped.
  assign s_axis_result_tready = (state_q != ST_ISSUE);

  assign m_axis_a_tdata    = a_data_q;
  assign m_axis_a_tvalid   = a_vld_q;
  assign m_axis_b_tdata    = b_data_q;
  assign m_axis_b_tvalid   = b_vld_q;
  assign result_out        = result_q;
  assign result_valid_out  = result_vld_q;
  assign busy_out          = busy_q;
  assign timeout_out       = timeout_q;
  assign overrun_count_out = overrun_cnt_q;
  assign timeout_count_out = timeout_cnt_q;

endmodule

// File: tb/tb_axis_operand_issuer.sv
module tb_axis_operand_issuer;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          trigger_in;
  logic [W-1:0]  a_in, b_in;
  logic [W-1:0]  m_axis_a_tdata, m_axis_b_tdata;
  logic          m_axis_a_tvalid, m_axis_b_tvalid;
  logic          m_axis_a_tready, m_axis_b_tready;
  logic [W-1:0]  s_axis_result_tdata;
  logic          s_axis_result_tvalid, s_axis_result_tready;
  logic [W-1:0]  result_out;
  logic          result_valid_out, busy_out, timeout_out;
  logic [CW-1:0] overrun_count_out, timeout_count_out;

  int checks   = 0;
  int failures = 0;

  axis_operand_issuer #(.WIDTH(W), .TIMEOUT_CYCLES(16), .CNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trigger_in(trigger_in),
    .a_in(a_in), .b_in(b_in),
    .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tvalid(m_axis_a_tvalid),
    .m_axis_a_tready(m_axis_a_tready),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid),
    .m_axis_b_tready(m_axis_b_tready),
    .s_axis_result_tdata(s_axis_result_tdata),
    .s_axis_result_tvalid(s_axis_result_tvalid),
    .s_axis_result_tready(s_axis_result_tready),
    .result_out(result_out), .result_valid_out(result_valid_out),
    .busy_out(busy_out), .timeout_out(timeout_out),
    .overrun_count_out(overrun_count_out), .timeout_count_out(timeout_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    trigger_in = 1'b0;
    s_axis_result_tvalid = 1'b0;
    s_axis_result_tdata = '0;
    m_axis_a_tready = 1'b1;
    m_axis_b_tready = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (m_axis_a_tvalid !== 1'b0 || m_axis_b_tvalid !== 1'b0) begin failures++; $display("FAIL %s_tvalid got a=%0b b=%0b exp 0 0", tag, m_axis_a_tvalid, m_axis_b_tvalid); end
    checks++; if (m_axis_a_tdata !== '0 || m_axis_b_tdata !== '0) begin failures++; $display("FAIL %s_tdata got a=%h b=%h exp 0", tag, m_axis_a_tdata, m_axis_b_tdata); end
    checks++; if (result_out !== '0 || result_valid_out !== 1'b0) begin failures++; $display("FAIL %s_result got %h/%0b exp 0/0", tag, result_out, result_valid_out); end
    checks++; if (busy_out !== 1'b0 || timeout_out !== 1'b0) begin failures++; $display("FAIL %s_flags got busy=%0b to=%0b exp 0 0", tag, busy_out, timeout_out); end
    checks++; if (overrun_count_out !== '0 || timeout_count_out !== '0) begin failures++; $display("FAIL %s_counts got %0d %0d exp 0 0", tag, overrun_count_out, timeout_count_out); end
    checks++; if (s_axis_result_tready !== 1'b1) begin failures++; $display("FAIL %s_s_tready got %0b exp 1", tag, s_axis_result_tready); end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle_inputs();
    a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
    trigger_in = 1'b1;
    repeat (3) step();
    check_reset_values("reset_held");
    @(negedge clk_in);
    rst_in = 1'b0;
    trigger_in = 1'b0;
    step();
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    idle_inputs();
    for (int c = 0; c <= 12; c++) begin
      trigger_in = (c == 0);
      a_in = (c == 0) ? 32'h4040_0000 : 32'h0;
      b_in = (c == 0) ? 32'h4080_0000 : 32'h0;
      s_axis_result_tvalid = (c == 10);
      s_axis_result_tdata = (c == 10) ? 32'h3D23_D70A : 32'h0;
      checks++; if (m_axis_a_tvalid !== (c == 1) || m_axis_b_tvalid !== (c == 1)) begin failures++; $display("FAIL basic_tvalid c=%0d got a=%0b b=%0b exp %0b", c, m_axis_a_tvalid, m_axis_b_tvalid, (c == 1)); end
      checks++; if (busy_out !== (c >= 1 && c <= 10)) begin failures++; $display("FAIL basic_busy c=%0d got %0b exp %0b", c, busy_out, (c >= 1 && c <= 10)); end
      checks++; if (s_axis_result_tready !== (c != 1)) begin failures++; $display("FAIL basic_s_tready c=%0d got %0b exp %0b", c, s_axis_result_tready, (c != 1)); end
      checks++; if (result_valid_out !== (c == 11)) begin failures++; $display("FAIL basic_result_valid c=%0d got %0b exp %0b", c, result_valid_out, (c == 11)); end
      if (c == 1) begin
        checks++; if (m_axis_a_tdata !== 32'h4040_0000 || m_axis_b_tdata !== 32'h4080_0000) begin failures++; $display("FAIL basic_tdata got a=%h b=%h exp 40400000 40800000", m_axis_a_tdata, m_axis_b_tdata); end
      end
      if (c == 11) begin
        checks++; if (result_out !== 32'h3D23_D70A) begin failures++; $display("FAIL basic_result got %h exp 3d23d70a", result_out); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    for (int c = 0; c <= 11; c++) begin
      trigger_in = (c == 0);
      a_in = (c == 0) ? 32'h1111_1111 : 32'hA5A5_0000 + c;
      b_in = (c == 0) ? 32'h2222_2222 : 32'h5A5A_0000 + c;
      m_axis_a_tready = (c >= 3);
      m_axis_b_tready = (c >= 6);
      s_axis_result_tvalid = (c == 9);
      s_axis_result_tdata = 32'h1234_5678;
      checks++; if (m_axis_a_tvalid !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL bp_a_tvalid c=%0d got %0b exp %0b", c, m_axis_a_tvalid, (c >= 1 && c <= 3)); end
      checks++; if (m_axis_b_tvalid !== (c >= 1 && c <= 6)) begin failures++; $display("FAIL bp_b_tvalid c=%0d got %0b exp %0b", c, m_axis_b_tvalid, (c >= 1 && c <= 6)); end
      if (c >= 1 && c <= 3) begin
        checks++; if (m_axis_a_tdata !== 32'h1111_1111) begin failures++; $display("FAIL bp_a_tdata c=%0d got %h exp 11111111", c, m_axis_a_tdata); end
      end
      if (c >= 1 && c <= 6) begin
        checks++; if (m_axis_b_tdata !== 32'h2222_2222) begin failures++; $display("FAIL bp_b_tdata c=%0d got %h exp 22222222", c, m_axis_b_tdata); end
      end
      checks++; if (s_axis_result_tready !== !(c >= 1 && c <= 6)) begin failures++; $display("FAIL bp_s_tready c=%0d got %0b exp %0b", c, s_axis_result_tready, !(c >= 1 && c <= 6)); end
      checks++; if (result_valid_out !== (c == 10)) begin failures++; $display("FAIL bp_result_valid c=%0d got %0b exp %0b", c, result_valid_out, (c == 10)); end
      step();
    end
    checks++; if (result_out !== 32'h1234_5678) begin failures++; $display("FAIL bp_result got %h exp 12345678", result_out); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    for (int c = 0; c <= 22; c++) begin
      trigger_in = (c == 0);
      a_in = 32'h3F80_0000; b_in = 32'h4000_0000;
      s_axis_result_tvalid = (c == 20);
      s_axis_result_tdata = 32'hDEAD_BEEF;
      checks++; if (timeout_out !== (c == 18)) begin failures++; $display("FAIL to_pulse c=%0d got %0b exp %0b", c, timeout_out, (c == 18)); end
      checks++; if (busy_out !== (c >= 1 && c <= 17)) begin failures++; $display("FAIL to_busy c=%0d got %0b exp %0b", c, busy_out, (c >= 1 && c <= 17)); end
      checks++; if (result_valid_out !== 1'b0) begin failures++; $display("FAIL to_result_valid c=%0d got %0b exp 0", c, result_valid_out); end
      if (c == 20) begin
        checks++; if (s_axis_result_tready !== 1'b1) begin failures++; $display("FAIL to_late_tready got %0b exp 1", s_axis_result_tready); end
      end
      step();
    end
    checks++; if (timeout_count_out !== 16'd1) begin failures++; $display("FAIL to_count got %0d exp 1", timeout_count_out); end
    checks++; if (result_out !== 32'h1234_5678) begin failures++; $display("FAIL to_result_kept got %h exp 12345678", result_out); end
    idle_inputs();
  endtask

  task automatic test_expiry_result();
    idle_inputs();
    for (int c = 0; c <= 19; c++) begin
      trigger_in = (c == 0);
      a_in = 32'h4100_0000; b_in = 32'h4110_0000;
      s_axis_result_tvalid = (c == 17);
      s_axis_result_tdata = 32'hCAFE_F00D;
      checks++; if (timeout_out !== 1'b0) begin failures++; $display("FAIL exp_pulse c=%0d got %0b exp 0", c, timeout_out); end
      checks++; if (result_valid_out !== (c == 18)) begin failures++; $display("FAIL exp_result_valid c=%0d got %0b exp %0b", c, result_valid_out, (c == 18)); end
      checks++; if (busy_out !== (c >= 1 && c <= 17)) begin failures++; $display("FAIL exp_busy c=%0d got %0b exp %0b", c, busy_out, (c >= 1 && c <= 17)); end
      step();
    end
    checks++; if (result_out !== 32'hCAFE_F00D) begin failures++; $display("FAIL exp_result got %h exp cafef00d", result_out); end
    checks++; if (timeout_count_out !== 16'd1) begin failures++; $display("FAIL exp_to_count got %0d exp 1", timeout_count_out); end
    idle_inputs();
  endtask

  task automatic test_overrun();
    idle_inputs();
    for (int c = 0; c <= 14; c++) begin
      trigger_in = (c == 0 || c == 2 || c == 5 || c == 8 || c == 9);
      a_in = 32'h0A00_0000 + c; b_in = 32'h0B00_0000 + c;
      s_axis_result_tvalid = (c == 8 || c == 13);
      s_axis_result_tdata = (c == 8) ? 32'h0BAD_F00D : 32'h600D_600D;
      if (c == 3) begin
        checks++; if (overrun_count_out !== 16'd1) begin failures++; $display("FAIL ovr_count_c3 got %0d exp 1", overrun_count_out); end
      end
      if (c == 9) begin
        checks++; if (result_valid_out !== 1'b1 || result_out !== 32'h0BAD_F00D) begin failures++; $display("FAIL ovr_result got %0b/%h exp 1/0badf00d", result_valid_out, result_out); end
      end
      checks++; if (m_axis_a_tvalid !== (c == 1 || c == 10)) begin failures++; $display("FAIL ovr_a_tvalid c=%0d got %0b exp %0b", c, m_axis_a_tvalid, (c == 1 || c == 10)); end
      if (c == 10) begin
        checks++; if (m_axis_a_tdata !== 32'h0A00_0009 || m_axis_b_tdata !== 32'h0B00_0009) begin failures++; $display("FAIL ovr_tdata got a=%h b=%h exp 0a000009 0b000009", m_axis_a_tdata, m_axis_b_tdata); end
      end
      step();
    end
    checks++; if (overrun_count_out !== 16'd3) begin failures++; $display("FAIL ovr_count got %0d exp 3", overrun_count_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL ovr_final_busy got %0b exp 0", busy_out); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_issue();
    idle_inputs();
    trigger_in = 1'b1;
    a_in = 32'hAAAA_0001; b_in = 32'hBBBB_0002;
    m_axis_b_tready = 1'b0;
    step();
    trigger_in = 1'b0;
    checks++; if (m_axis_a_tvalid !== 1'b1 || m_axis_b_tvalid !== 1'b1) begin failures++; $display("FAIL mid_issue_start got a=%0b b=%0b exp 1 1", m_axis_a_tvalid, m_axis_b_tvalid); end
    step();
    checks++; if (m_axis_a_tvalid !== 1'b0 || m_axis_b_tvalid !== 1'b1) begin failures++; $display("FAIL mid_issue_pending got a=%0b b=%0b exp 0 1", m_axis_a_tvalid, m_axis_b_tvalid); end
    #1 rst_in = 1'b1;
    #1;
    check_reset_values("mid_async");
    @(negedge clk_in);
    rst_in = 1'b0;
    idle_inputs();
    step();
    trigger_in = 1'b1;
    a_in = 32'h0102_0304; b_in = 32'h0506_0708;
    step();
    trigger_in = 1'b0;
    checks++; if (m_axis_a_tvalid !== 1'b1 || m_axis_b_tvalid !== 1'b1 || m_axis_a_tdata !== 32'h0102_0304 || m_axis_b_tdata !== 32'h0506_0708) begin failures++; $display("FAIL post_reset_issue got %0b%0b %h %h exp 11 01020304 05060708", m_axis_a_tvalid, m_axis_b_tvalid, m_axis_a_tdata, m_axis_b_tdata); end
    step();
    checks++; if (m_axis_a_tvalid !== 1'b0 || m_axis_b_tvalid !== 1'b0 || busy_out !== 1'b1 || s_axis_result_tready !== 1'b1) begin failures++; $display("FAIL post_reset_wait got tv=%0b%0b busy=%0b rdy=%0b exp 00 1 1", m_axis_a_tvalid, m_axis_b_tvalid, busy_out, s_axis_result_tready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_expiry_result();
    test_overrun();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
